// File: rtl/aw_channel_issuer.sv
// AXI4 write-address channel issuer: queues local write commands, presents them on AW
// with stable payload until accepted, and limits in-flight writes using B completions.
module aw_channel_issuer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [ID_WIDTH-1:0]           req_id,
    input  logic [7:0]                    req_len,
    input  logic [2:0]                    req_size,
    input  logic [1:0]                    req_burst,
    output logic                          M_AWVALID,
    input  logic                          M_AWREADY,
    output logic [ADDR_WIDTH-1:0]         M_AWADDR,
    output logic [ID_WIDTH-1:0]           M_AWID,
    output logic [7:0]                    M_AWLEN,
    output logic [2:0]                    M_AWSIZE,
    output logic [1:0]                    M_AWBURST,
    input  logic                          B_Done,
    output logic                          HandShake_Done,
    output logic [7:0]                    outstanding,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          b_underflow
);

    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam int              EW        = ADDR_WIDTH + ID_WIDTH + 13;
    localparam logic [7:0]      MAX_OUT   = 8'(MAX_OUTSTANDING);
    localparam logic [PW:0]     DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]     CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_THROTTLE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [EW-1:0]   r_aw_entry;
    logic            r_awvalid;
    logic            r_hs;
    logic [7:0]      r_outstanding;
    logic            r_b_underflow;
    logic [7:0]      w_out_next;
    logic            w_underflow_hit;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_load;
    logic            w_aw_fire;
    logic            w_head_ok;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == {(PW+1){1'b0}});
    assign w_push    = req_valid & ~w_full;
    assign w_aw_fire = r_awvalid & M_AWREADY;
    // A head may be loaded only if the credit left after this edge's AW/B activity allows it.
    assign w_head_ok = ~w_empty & (w_out_next < MAX_OUT);

    assign req_ready      = ~w_full;
    assign M_AWVALID      = r_awvalid;
    assign {M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST} = r_aw_entry;
    assign HandShake_Done = r_hs;
    assign outstanding    = r_outstanding;
    assign fifo_count     = r_count;
    assign b_underflow    = r_b_underflow;

    // Outstanding count after this edge; an unmatched B with nothing in flight is flagged.
    always_comb begin
        w_out_next      = r_outstanding;
        w_underflow_hit = 1'b0;
        if (w_aw_fire && !B_Done) begin
            w_out_next = r_outstanding + 8'd1;
        end else if (!w_aw_fire && B_Done) begin
            if (r_outstanding != 8'd0) begin
                w_out_next = r_outstanding - 8'd1;
            end else begin
                w_underflow_hit = 1'b1;
            end
        end else begin
            w_out_next = r_outstanding;
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_THROTTLE: begin
                if (w_head_ok)     w_state_next = S_ISSUE;
                else if (!w_empty) w_state_next = S_THROTTLE;
                else               w_state_next = S_IDLE;
            end
            S_ISSUE: begin
                if (!w_aw_fire)    w_state_next = S_ISSUE;
                else if (w_head_ok) w_state_next = S_ISSUE;
                else if (!w_empty) w_state_next = S_THROTTLE;
                else               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Queue-head load decode.
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            S_IDLE:     w_load = w_head_ok;
            S_ISSUE:    w_load = w_aw_fire & w_head_ok;
            S_THROTTLE: w_load = w_head_ok;
            default:    w_load = 1'b0;
        endcase
    end

    // Queue pointers and occupancy; a full queue refuses pushes even while popping.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are invalidated by pointer reset alone.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_addr, req_id, req_len, req_size, req_burst};
        end
    end

    // AW valid/payload registers and the handshake pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awvalid  <= 1'b0;
            r_aw_entry <= {EW{1'b0}};
            r_hs       <= 1'b0;
        end else begin
            r_awvalid <= (w_state_next == S_ISSUE);
            r_hs      <= w_aw_fire;
            if (w_load) begin
                r_aw_entry <= r_mem[r_rd_ptr];
            end
        end
    end

    // In-flight write tracking and sticky underflow flag.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_outstanding <= 8'd0;
            r_b_underflow <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_underflow_hit) r_b_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aw_channel_issuer.sv
// Self-checking bench for aw_channel_issuer: a queue-based reference model of the
// command flow is stepped every clock and compared against the DUT each cycle.
module tb_aw_channel_issuer;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    logic        ACLK = 1'b0;
    logic        ARESET, req_valid, M_AWREADY, B_Done;
    logic [31:0] req_addr;
    logic [3:0]  req_id;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        req_ready, M_AWVALID, HandShake_Done, b_underflow;
    logic [31:0] M_AWADDR;
    logic [3:0]  M_AWID;
    logic [7:0]  M_AWLEN;
    logic [2:0]  M_AWSIZE;
    logic [1:0]  M_AWBURST;
    logic [7:0]  outstanding;
    logic [2:0]  fifo_count;

    cmd_t m_q[$];
    cmd_t m_pay;
    bit   m_valid, m_hs, m_under;
    int   m_out;
    cmd_t pushed[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 ACLK = ~ACLK;

    aw_channel_issuer #(.ADDR_WIDTH(32), .ID_WIDTH(4), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_id(req_id), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_AWADDR(M_AWADDR), .M_AWID(M_AWID), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .B_Done(B_Done), .HandShake_Done(HandShake_Done),
        .outstanding(outstanding), .fifo_count(fifo_count), .b_underflow(b_underflow)
    );

    function automatic logic [63:0] obs_vec();
        return {M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST,
                HandShake_Done, outstanding, fifo_count, req_ready, b_underflow};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {m_valid, m_pay, m_hs, 8'(m_out), 3'(m_q.size()), (m_q.size() < DEPTH), m_under};
    endfunction

    function automatic cmd_t cur_cmd();
        return {req_addr, req_id, req_len, req_size, req_burst};
    endfunction

    task automatic rand_cmd();
        req_addr  = $urandom;
        req_id    = 4'($urandom_range(0, 15));
        req_len   = 8'($urandom_range(0, 255));
        req_size  = 3'($urandom_range(0, 7));
        req_burst = 2'($urandom_range(0, 2));
    endtask

    // One clock edge; the model applies the command-flow rules to the inputs seen at that edge.
    task automatic tick();
        bit fire, push, load;
        int pre_size;
        @(posedge ACLK);
        if (ARESET) begin
            m_q.delete();
            m_valid = 1'b0; m_pay = '0; m_out = 0; m_hs = 1'b0; m_under = 1'b0;
        end else begin
            pre_size = m_q.size();
            fire = m_valid && M_AWREADY;
            push = req_valid && (pre_size < DEPTH);
            if (fire && !B_Done) m_out = m_out + 1;
            else if (!fire && B_Done) begin
                if (m_out > 0) m_out = m_out - 1;
                else m_under = 1'b1;
            end
            load = (!m_valid || fire) && (pre_size > 0) && (m_out < MAXO);
            if (load) begin
                m_pay = m_q.pop_front();
                m_valid = 1'b1;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            m_hs = fire;
            if (push) m_q.push_back(cur_cmd());
        end
        #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; req_valid = 1'b1; M_AWREADY = 1'b1; B_Done = 1'b1; rand_cmd();
        for (int i = 0; i < 2; i++) begin
            tick();
            if (obs_vec() !== exp_vec()) $display("FAIL reset cyc%0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
        end
        ARESET = 1'b0; req_valid = 1'b0; B_Done = 1'b0; M_AWREADY = 1'b0;
        tick();
        if ({M_AWVALID, req_ready, outstanding, fifo_count} !== {1'b0, 1'b1, 8'd0, 3'd0})
            $display("FAIL reset_release: dut=%h want=%h", {M_AWVALID, req_ready, outstanding, fifo_count}, {1'b0, 1'b1, 8'd0, 3'd0});
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_single();
        M_AWREADY = 1'b1; req_valid = 1'b1;
        req_addr = 32'h0000_1000; req_id = 4'd3; req_len = 8'd7; req_size = 3'd2; req_burst = 2'd1;
        tick();
        req_valid = 1'b0;
        if (obs_vec() !== exp_vec()) $display("FAIL single_push: dut=%h model=%h", obs_vec(), exp_vec());
        else n_pass++;
        n_chk++;
        tick();
        if ({M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST} !== {1'b1, 32'h0000_1000, 4'd3, 8'd7, 3'd2, 2'd1})
            $display("FAIL single_aw: dut=%h want=%h", {M_AWVALID, M_AWADDR, M_AWID, M_AWLEN}, {1'b1, 32'h0000_1000, 4'd3, 8'd7});
        else n_pass++;
        n_chk++;
        tick();
        if ({M_AWVALID, HandShake_Done, outstanding} !== {1'b0, 1'b1, 8'd1})
            $display("FAIL single_hs: dut=%h want=%h", {M_AWVALID, HandShake_Done, outstanding}, {1'b0, 1'b1, 8'd1});
        else n_pass++;
        n_chk++;
        B_Done = 1'b1;
        tick();
        B_Done = 1'b0;
        if ({HandShake_Done, outstanding, b_underflow} !== {1'b0, 8'd0, 1'b0})
            $display("FAIL single_b: dut=%h want=%h", {HandShake_Done, outstanding, b_underflow}, {1'b0, 8'd0, 1'b0});
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_stall();
        pushed.delete();
        M_AWREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_cmd(); req_valid = 1'b1; pushed.push_back(cur_cmd());
            tick();
            if (obs_vec() !== exp_vec()) $display("FAIL stall_push%0d: dut=%h model=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            M_AWREADY = 1'b0;
            tick();
            if ({M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST} !== {1'b1, pushed[0]})
                $display("FAIL stall_hold%0d: dut=%h want=%h", k, {M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST}, {1'b1, pushed[0]});
            else n_pass++;
            n_chk++;
        end
        M_AWREADY = 1'b1; B_Done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if ({M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST} !== {1'b1, pushed[k]})
                $display("FAIL stall_order%0d: dut=%h want=%h", k, {M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST}, {1'b1, pushed[k]});
            else n_pass++;
            n_chk++;
            tick();
        end
        B_Done = 1'b0; M_AWREADY = 1'b0;
        if (obs_vec() !== exp_vec()) $display("FAIL stall_drained: dut=%h model=%h", obs_vec(), exp_vec());
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_throttle();
        M_AWREADY = 1'b1; B_Done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_cmd(); req_valid = 1'b1;
            tick();
            if (obs_vec() !== exp_vec()) $display("FAIL thr_push%0d: dut=%h model=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if ({M_AWVALID, fifo_count, outstanding} !== {1'b0, 3'd2, 8'd2})
                $display("FAIL thr_block%0d: dut=%h want=%h", k, {M_AWVALID, fifo_count, outstanding}, {1'b0, 3'd2, 8'd2});
            else n_pass++;
            n_chk++;
        end
        B_Done = 1'b1;
        tick();
        B_Done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (obs_vec() !== exp_vec()) $display("FAIL thr_release%0d: dut=%h model=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
            tick();
        end
        if ({M_AWVALID, fifo_count, outstanding} !== {1'b0, 3'd1, 8'd2})
            $display("FAIL thr_one_more: dut=%h want=%h", {M_AWVALID, fifo_count, outstanding}, {1'b0, 3'd1, 8'd2});
        else n_pass++;
        n_chk++;
        B_Done = 1'b1; M_AWREADY = 1'b0;
        tick();
        M_AWREADY = 1'b1;
        tick();
        if ({HandShake_Done, outstanding} !== {1'b1, 8'd1})
            $display("FAIL thr_same_edge: dut=%h want=%h", {HandShake_Done, outstanding}, {1'b1, 8'd1});
        else n_pass++;
        n_chk++;
        tick();
        B_Done = 1'b0; M_AWREADY = 1'b0;
        if (obs_vec() !== exp_vec()) $display("FAIL thr_end: dut=%h model=%h", obs_vec(), exp_vec());
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_full_wrap();
        pushed.delete();
        M_AWREADY = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            rand_cmd(); pushed.push_back(cur_cmd());
            tick();
            if (obs_vec() !== exp_vec()) $display("FAIL full_push%0d: dut=%h model=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
        end
        req_valid = 1'b0;
        if ({req_ready, fifo_count} !== {1'b0, 3'd4})
            $display("FAIL full_ready: dut=%h want=%h", {req_ready, fifo_count}, {1'b0, 3'd4});
        else n_pass++;
        n_chk++;
        M_AWREADY = 1'b1; B_Done = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            if ({M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST} !== {1'b1, pushed[k]})
                $display("FAIL wrap_order%0d: dut=%h want=%h", k, {M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST}, {1'b1, pushed[k]});
            else n_pass++;
            n_chk++;
            tick();
        end
        M_AWREADY = 1'b0;
        if ({M_AWVALID, fifo_count, outstanding, b_underflow} !== {1'b0, 3'd0, 8'd0, 1'b0})
            $display("FAIL wrap_empty: dut=%h want=%h", {M_AWVALID, fifo_count, outstanding, b_underflow}, {1'b0, 3'd0, 8'd0, 1'b0});
        else n_pass++;
        n_chk++;
        tick();
        B_Done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if ({b_underflow, outstanding} !== {1'b1, 8'd0})
                $display("FAIL underflow%0d: dut=%h want=%h", k, {b_underflow, outstanding}, {1'b1, 8'd0});
            else n_pass++;
            n_chk++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_cmd();
            req_valid = ($urandom_range(0, 99) < 60);
            M_AWREADY = ($urandom_range(0, 99) < 55);
            B_Done    = (m_out > 0) ? ($urandom_range(0, 99) < 35) : 1'b0;
            tick();
            if (obs_vec() !== exp_vec()) $display("FAIL random cyc%0d: dut=%h model=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            n_chk++;
        end
        req_valid = 1'b0; M_AWREADY = 1'b0; B_Done = 1'b0;
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 3; k++) begin
            rand_cmd(); req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        if (obs_vec() !== exp_vec()) $display("FAIL midrst_pre: dut=%h model=%h", obs_vec(), exp_vec());
        else n_pass++;
        n_chk++;
        ARESET = 1'b1;
        tick();
        if (obs_vec() !== {1'b0, 49'd0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0})
            $display("FAIL midrst: dut=%h want=%h", obs_vec(), {1'b0, 49'd0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0});
        else n_pass++;
        n_chk++;
        ARESET = 1'b0;
        tick();
        if (obs_vec() !== exp_vec()) $display("FAIL midrst_post: dut=%h model=%h", obs_vec(), exp_vec());
        else n_pass++;
        n_chk++;
    endtask

    initial begin
        ARESET = 1'b1; req_valid = 1'b0; M_AWREADY = 1'b0; B_Done = 1'b0;
        req_addr = 32'd0; req_id = 4'd0; req_len = 8'd0; req_size = 3'd0; req_burst = 2'd0;
        m_valid = 1'b0; m_pay = '0; m_out = 0; m_hs = 1'b0; m_under = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_throttle();
        test_full_wrap();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
